// File: rtl/counter_pkg.sv
// Shared types for the mode counter: terminal-mode encoding and its decode helper.
package counter_pkg;

    typedef enum logic [1:0] {
        CNT_WRAP    = 2'd0,
        CNT_SAT     = 2'd1,
        CNT_ONESHOT = 2'd2,
        CNT_RSVD    = 2'd3
    } cnt_mode_e;

    // The reserved encoding folds onto WRAP so every mode input has defined behaviour.
    function automatic cnt_mode_e decodeMode(input logic [1:0] modeRaw);
        cnt_mode_e result;
        case (modeRaw)
            2'd1:    result = CNT_SAT;
            2'd2:    result = CNT_ONESHOT;
            default: result = CNT_WRAP;
        endcase
        return result;
    endfunction

endpackage

// File: rtl/counter_prescaler.sv
// Divides qualifying cycles so that only every (prescale+1)-th one becomes a step.
// Only built when CNT_PRESCALE_EN is defined.
`ifdef CNT_PRESCALE_EN
module counter_prescaler #(
    parameter int PRESCALE_WIDTH = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      clear,
    input  logic                      enable,
    input  logic [PRESCALE_WIDTH-1:0] prescale,
    output logic                      step_en
);

    logic [PRESCALE_WIDTH-1:0] divCnt_q, divCnt_d;
    logic                      atEnd;

    // Compare with >= so a prescale lowered mid-period fires promptly instead of running the full wrap.
    assign atEnd   = (divCnt_q >= prescale);
    assign step_en = enable && atEnd;

    always_comb begin
        divCnt_d = divCnt_q;
        if (clear) begin
            divCnt_d = '0;
        end else if (enable) begin
            divCnt_d = atEnd ? '0 : divCnt_q + PRESCALE_WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            divCnt_q <= '0;
        end else begin
            divCnt_q <= divCnt_d;
        end
    end

endmodule
`endif

// File: rtl/mode_counter.sv
// Loadable up/down counter with programmable limit, WRAP/SAT/ONESHOT terminal modes and a registered tc pulse.
// Optional prescaler on the step path is enabled by defining CNT_PRESCALE_EN.
module mode_counter
    import counter_pkg::*;
#(
`ifdef CNT_PRESCALE_EN
    parameter int PRESCALE_WIDTH = 8,
`endif
    parameter int WIDTH      = 16,
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  load,
    input  logic [DATA_WIDTH-1:0] data_in,
`ifdef CNT_PRESCALE_EN
    input  logic [PRESCALE_WIDTH-1:0] prescale,
`endif
    input  logic                  dir,
    input  logic [1:0]            mode,
    input  logic [WIDTH-1:0]      limit,
    output logic [WIDTH-1:0]      count,
    output logic                  tc,
    output logic                  done
);

    logic [WIDTH-1:0] count_q, count_d;
    logic             tc_q, tc_d;
    logic             done_q, done_d;
    logic             qualify;
    logic             step;
    logic             atTerm;
    cnt_mode_e        modeDec;

    assign qualify = enable && !load && !done_q;

`ifdef CNT_PRESCALE_EN
    counter_prescaler #(
        .PRESCALE_WIDTH(PRESCALE_WIDTH)
    ) uPrescaler (
        .clk      (clk),
        .reset    (reset),
        .clear    (load || done_q),
        .enable   (qualify),
        .prescale (prescale),
        .step_en  (step)
    );
`else
    assign step = qualify;
`endif

    // Up uses >= so a limit lowered beneath the current count still counts as terminal.
    assign atTerm  = dir ? (count_q == '0) : (count_q >= limit);
    assign modeDec = decodeMode(mode);

    always_comb begin
        count_d = count_q;
        tc_d    = 1'b0;
        done_d  = done_q;
        if (load) begin
            count_d = WIDTH'(data_in);
            done_d  = 1'b0;
        end else if (step) begin
            if (!atTerm) begin
                count_d = dir ? count_q - WIDTH'(1) : count_q + WIDTH'(1);
            end else begin
                tc_d = 1'b1;
                case (modeDec)
                    CNT_SAT:     count_d = count_q;
                    CNT_ONESHOT: done_d  = 1'b1;
                    default:     count_d = dir ? limit : '0;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
            tc_q    <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            tc_q    <= tc_d;
            done_q  <= done_d;
        end
    end

    assign count = count_q;
    assign tc    = tc_q;
    assign done  = done_q;

endmodule
